// File: rtl/antic_pkg.sv
// Shared definitions for the ANTIC display-list DMA: FSM states and opcode field decode.
package antic_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_OP = 3'd1,
        FETCH_LO = 3'd2,
        FETCH_HI = 3'd3,
        PRESENT  = 3'd4,
        WAIT_VB  = 3'd5
    } dl_state_e;

    localparam logic [3:0] MODE_JMP = 4'd1;
    localparam int         BIT_LMS  = 6;
    localparam int         BIT_DLI  = 7;

    function automatic logic is_jump(input logic [7:0] op);
        return op[3:0] == MODE_JMP;
    endfunction

    // Jumps also carry bit 6 (JVB), so LMS is only meaningful for mode nibbles >= 2.
    function automatic logic is_lms(input logic [7:0] op);
        return (op[3:0] >= 4'd2) && op[BIT_LMS];
    endfunction

    function automatic logic is_fetch(input dl_state_e s);
        return (s == FETCH_OP) || (s == FETCH_LO) || (s == FETCH_HI);
    endfunction

endpackage

// File: rtl/dl_ptr_counter.sv
// Display-list pointer: parallel load, otherwise increments only the low WRAP_W bits.
module dl_ptr_counter #(
    parameter int ADDR_W = 16,
    parameter int WRAP_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] ptr
);

    // Upper bits hold on increment, so a list never crosses its wrap block sequentially.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= {ptr[ADDR_W-1:WRAP_W], ptr[WRAP_W-1:0] + 1'b1};
        end
    end

endmodule

// File: rtl/antic_dlist_dma.sv
// Display-list DMA: fetches opcodes and operands by stealing bus cycles and hands
// displayable instructions to the line generator over a valid/ready handshake.
module antic_dlist_dma
    import antic_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int WRAP_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              phi2,
    input  logic              RST,
    input  logic              dma_en,
    input  logic              dl_load,
    input  logic [ADDR_W-1:0] dl_base,
    input  logic              vblank,
    input  logic [DATA_W-1:0] DB,
    output logic [ADDR_W-1:0] address,
    output logic              halt_L,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr,
    output logic              lms_valid,
    output logic [ADDR_W-1:0] lms_addr,
    output logic [ADDR_W-1:0] dlist_ptr,
    output logic [2:0]        cstate
);

    if (DATA_W != 8) begin : g_data_w_check
        $error("antic_dlist_dma: DATA_W must be 8");
    end

    dl_state_e         state, state_nxt;
    logic              ptr_inc, ptr_load;
    logic [ADDR_W-1:0] ptr_load_val;
    logic [7:0]        jmp_lo;
    logic              lms_q;
    logic              halt_q;

    dl_ptr_counter #(.ADDR_W(ADDR_W), .WRAP_W(WRAP_W)) u_ptr (
        .clk      (phi2),
        .rst      (RST),
        .load     (ptr_load),
        .inc      (ptr_inc),
        .load_val (ptr_load_val),
        .ptr      (dlist_ptr)
    );

    always_ff @(posedge phi2 or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Handshake: instr_valid is high throughout PRESENT; instr, lms_valid and lms_addr
    // hold until the edge where instr_valid && instr_ready, after which FETCH_OP follows.
    always_comb begin
        state_nxt    = state;
        ptr_inc      = 1'b0;
        ptr_load     = 1'b0;
        ptr_load_val = dl_base;
        case (state)
            IDLE: if (dma_en) state_nxt = FETCH_OP;
            FETCH_OP: begin
                ptr_inc = 1'b1;
                if (!dma_en)                       state_nxt = IDLE;
                else if (is_jump(DB) || is_lms(DB)) state_nxt = FETCH_LO;
                else                               state_nxt = PRESENT;
            end
            FETCH_LO: begin
                ptr_inc   = 1'b1;
                state_nxt = dma_en ? FETCH_HI : IDLE;
            end
            FETCH_HI: begin
                if (is_jump(instr)) begin
                    ptr_load     = 1'b1;
                    ptr_load_val = ADDR_W'({DB, jmp_lo});
                    if (!dma_en)              state_nxt = IDLE;
                    else if (instr[BIT_LMS])  state_nxt = WAIT_VB;
                    else                      state_nxt = FETCH_OP;
                end else begin
                    ptr_inc   = 1'b1;
                    state_nxt = dma_en ? PRESENT : IDLE;
                end
            end
            PRESENT: if (instr_ready) state_nxt = dma_en ? FETCH_OP : IDLE;
            WAIT_VB: begin
                if (!dma_en)     state_nxt = IDLE;
                else if (vblank) state_nxt = FETCH_OP;
            end
            default: state_nxt = IDLE;
        endcase
        if (dl_load) begin
            ptr_load     = 1'b1;
            ptr_inc      = 1'b0;
            ptr_load_val = dl_base;
            state_nxt    = dma_en ? FETCH_OP : IDLE;
        end
    end

    always_ff @(posedge phi2 or posedge RST) begin
        if (RST) begin
            instr    <= '0;
            lms_addr <= '0;
            jmp_lo   <= '0;
            lms_q    <= 1'b0;
            halt_q   <= 1'b1;
        end else begin
            // halt_L comes straight from a flop so the bus never sees a decode glitch.
            halt_q <= !is_fetch(state_nxt);
            if (!dl_load) begin
                case (state)
                    FETCH_OP: begin
                        instr <= DB;
                        lms_q <= 1'b0;
                    end
                    FETCH_LO: begin
                        if (is_jump(instr)) jmp_lo        <= DB;
                        else                lms_addr[7:0] <= DB;
                    end
                    FETCH_HI: begin
                        if (!is_jump(instr)) begin
                            lms_addr <= ADDR_W'({DB, lms_addr[7:0]});
                            lms_q    <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign address     = dlist_ptr;
    assign halt_L      = halt_q;
    assign instr_valid = (state == PRESENT);
    assign lms_valid   = lms_q && instr_valid;
    assign cstate      = state;

endmodule

// File: tb/tb_antic_dlist_dma.sv
// Directed bench for antic_dlist_dma against a byte-wide memory model.
module tb_antic_dlist_dma;

    localparam int ADDR_W = 16;
    localparam int WRAP_W = 10;
    localparam int DATA_W = 8;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH_OP = 3'd1, S_FETCH_LO = 3'd2,
                           S_FETCH_HI = 3'd3, S_PRESENT = 3'd4, S_WAIT_VB = 3'd5;

    logic              phi2 = 1'b0;
    logic              rst;
    logic              dma_en, dl_load, vblank, instr_ready;
    logic [ADDR_W-1:0] dl_base;
    logic [DATA_W-1:0] db;
    logic [ADDR_W-1:0] address, lms_addr, dlist_ptr;
    logic              halt_L, instr_valid, lms_valid;
    logic [7:0]        instr;
    logic [2:0]        cstate;

    logic [7:0] mem [0:65535];
    logic [7:0] exp_q[$];

    int assert_count = 0;
    int fail_count   = 0;

    // ---------------- clock / reset ----------------
    always #5 phi2 = ~phi2;

    antic_dlist_dma #(.ADDR_W(ADDR_W), .WRAP_W(WRAP_W), .DATA_W(DATA_W)) dut (
        .phi2        (phi2),
        .RST         (rst),
        .dma_en      (dma_en),
        .dl_load     (dl_load),
        .dl_base     (dl_base),
        .vblank      (vblank),
        .DB          (db),
        .address     (address),
        .halt_L      (halt_L),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .lms_valid   (lms_valid),
        .lms_addr    (lms_addr),
        .dlist_ptr   (dlist_ptr),
        .cstate      (cstate)
    );

    assign db = halt_L ? 8'h00 : mem[address];

    // ---------------- checker / driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge phi2);
        #1;
    endtask

    task automatic load_list(input logic [ADDR_W-1:0] base);
        dl_base = base;
        dl_load = 1'b1;
        step();
        dl_load = 1'b0;
    endtask

    // Waits (bounded) for instr_valid, counting cycles with halt_L low on the way.
    task automatic wait_valid(input int max_cycles, output int lows, output logic seen);
        lows = 0;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (instr_valid) begin
                seen = 1'b1;
                break;
            end
            if (!halt_L) lows++;
            step();
        end
        if (!seen) seen = instr_valid;
    endtask

    task automatic expect_instr(input string tag, input int exp_lows);
        int   lows;
        logic seen;
        logic [7:0] exp_op;
        wait_valid(10, lows, seen);
        check({tag, "_valid"}, 32'(seen), 32'd1);
        exp_op = exp_q.pop_front();
        check({tag, "_instr"}, 32'(instr), 32'(exp_op));
        check({tag, "_halt_lows"}, 32'(lows), 32'(exp_lows));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   vcount;
        logic reached;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h2000] = 8'h70; mem[16'h2001] = 8'h42; mem[16'h2002] = 8'h00;
        mem[16'h2003] = 8'h30; mem[16'h2004] = 8'h02; mem[16'h2005] = 8'h41;
        mem[16'h2006] = 8'h00; mem[16'h2007] = 8'h20;
        mem[16'h23FF] = 8'h02; mem[16'h2400] = 8'h0F;

        rst = 1'b1; dma_en = 1'b0; dl_load = 1'b0; dl_base = '0;
        vblank = 1'b0; instr_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        check("rst_state",    32'(cstate),      32'(S_IDLE));
        check("rst_halt",     32'(halt_L),      32'd1);
        check("rst_valid",    32'(instr_valid), 32'd0);
        check("rst_lms_valid",32'(lms_valid),   32'd0);
        check("rst_instr",    32'(instr),       32'd0);
        check("rst_address",  32'(address),     32'd0);
        check("rst_ptr",      32'(dlist_ptr),   32'd0);
        check("rst_lms_addr", 32'(lms_addr),    32'd0);

        // Blank, LMS, plain mode, then JVB.
        dma_en = 1'b1;
        load_list(16'h2000);
        check("s1_fetch_state", 32'(cstate),  32'(S_FETCH_OP));
        check("s1_fetch_addr",  32'(address), 32'h2000);
        check("s1_fetch_halt",  32'(halt_L),  32'd0);
        exp_q.push_back(8'h70);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h02);
        expect_instr("blank", 1);
        check("blank_lms_valid", 32'(lms_valid), 32'd0);
        step();
        expect_instr("lms", 3);
        check("lms_valid",    32'(lms_valid), 32'd1);
        check("lms_addr",     32'(lms_addr),  32'h3000);
        check("lms_ptr",      32'(dlist_ptr), 32'h2004);
        check("lms_halt_hi",  32'(halt_L),    32'd1);
        step();
        expect_instr("mode2", 1);
        check("mode2_lms_valid", 32'(lms_valid), 32'd0);
        step();

        vcount = 0; reached = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (cstate == S_WAIT_VB) begin
                reached = 1'b1;
                break;
            end
            if (instr_valid) vcount++;
            step();
        end
        check("jvb_reached",   32'(reached),   32'd1);
        check("jvb_no_present",32'(vcount),    32'd0);
        repeat (3) step();
        check("jvb_hold_state",32'(cstate),    32'(S_WAIT_VB));
        check("jvb_halt",      32'(halt_L),    32'd1);
        check("jvb_ptr",       32'(dlist_ptr), 32'h2000);
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        check("vb_state", 32'(cstate),  32'(S_FETCH_OP));
        check("vb_addr",  32'(address), 32'h2000);
        exp_q.push_back(8'h70);
        expect_instr("vb_refetch", 1);

        // Wrap across the 1 KiB block boundary.
        mem[16'h2000] = 8'h41;
        load_list(16'h23FF);
        exp_q.push_back(8'h02);
        expect_instr("wrap", 1);
        check("wrap_ptr", 32'(dlist_ptr), 32'h2000);
        step();
        check("wrap_next_addr", 32'(address), 32'h2000);
        step();
        check("wrap_next_op",   32'(instr),   32'h41);
        mem[16'h2000] = 8'h70;

        // Backpressure.
        instr_ready = 1'b0;
        load_list(16'h2000);
        exp_q.push_back(8'h70);
        expect_instr("bp", 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_instr", 32'(instr),       32'h70);
            check("bp_halt",  32'(halt_L),      32'd1);
        end
        instr_ready = 1'b1;
        step();
        check("bp_accept_state", 32'(cstate),      32'(S_FETCH_OP));
        check("bp_accept_valid", 32'(instr_valid), 32'd0);
        check("bp_accept_addr",  32'(address),     32'h2001);

        // Abort an LMS during its low-byte fetch.
        step();
        check("abort_in_lo", 32'(cstate), 32'(S_FETCH_LO));
        dl_base = 16'h2005;
        dl_load = 1'b1;
        step();
        dl_load = 1'b0;
        check("abort_state", 32'(cstate),  32'(S_FETCH_OP));
        check("abort_addr",  32'(address), 32'h2005);
        step();
        check("abort_op",    32'(instr),   32'h41);

        // Asynchronous reset in the middle of FETCH_HI.
        step();
        check("rst_mid_state_hi", 32'(cstate), 32'(S_FETCH_HI));
        check("rst_mid_halt_lo",  32'(halt_L), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_halt",  32'(halt_L),      32'd1);
        check("rst_async_valid", 32'(instr_valid), 32'd0);
        check("rst_async_state", 32'(cstate),      32'(S_IDLE));
        check("rst_async_ptr",   32'(dlist_ptr),   32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("post_rst_idle", 32'(cstate), 32'(S_IDLE));
        step();
        check("post_rst_fetch", 32'(cstate),  32'(S_FETCH_OP));
        check("post_rst_addr",  32'(address), 32'h0000);

        // dma_en dropped while presenting: handshake completes, then IDLE.
        instr_ready = 1'b0;
        load_list(16'h2000);
        exp_q.push_back(8'h70);
        expect_instr("dis", 1);
        dma_en = 1'b0;
        step();
        check("dis_hold", 32'(cstate), 32'(S_PRESENT));
        instr_ready = 1'b1;
        step();
        check("dis_idle", 32'(cstate), 32'(S_IDLE));
        check("dis_halt", 32'(halt_L), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
